// File: rtl/bpm2per_if.sv
// rtl/bpm2per_if.sv - request/result bus between a tempo source and the bpm2per converter.
interface bpm2per_if #(
    parameter int PER_WIDTH = 24,
    parameter int BPM_WIDTH = 8
);
    logic [BPM_WIDTH-1:0] bpm_i;
    logic                 bpm_valid;
    logic [PER_WIDTH-1:0] btn_per_o;
    logic                 btn_per_valid;
    logic                 busy_o;

    modport master (
        output bpm_i, bpm_valid,
        input  btn_per_o, btn_per_valid, busy_o
    );

    modport slave (
        input  bpm_i, bpm_valid,
        output btn_per_o, btn_per_valid, busy_o
    );
endinterface

// File: rtl/bpm2per.sv
// rtl/bpm2per.sv - BPM to beat period (floor(PER_CONST/bpm)) via a 1-bit/clock restoring divider.
// Optional beat generator enabled by defining BPM2PER_PULSE_EN.
module bpm2per #(
    parameter int PER_WIDTH = 24,
    parameter int BPM_WIDTH = 8,
    parameter int PER_CONST = 60000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    bpm2per_if.slave   bus
`ifdef BPM2PER_PULSE_EN
    ,
    input  logic       tick_i,
    output logic       beat_o
`endif
);
    localparam int CNT_W = $clog2(PER_WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [BPM_WIDTH-1:0] r_div;
    logic [BPM_WIDTH-1:0] r_rem;
    logic [PER_WIDTH-1:0] r_dvd;
    logic [CNT_W-1:0]     r_cnt;
    logic [PER_WIDTH-1:0] r_per;
    logic                 r_valid;

    logic [BPM_WIDTH:0]   w_sh;
    logic [BPM_WIDTH:0]   w_div_ext;
    logic                 w_ge;
    logic [BPM_WIDTH-1:0] w_rem_nx;
    logic [PER_WIDTH-1:0] w_q_nx;

    // Remainder stays below the divisor, so BPM_WIDTH bits suffice; with a zero
    // divisor every step subtracts nothing and the quotient saturates to all ones.
    assign w_sh      = {r_rem, r_dvd[PER_WIDTH-1]};
    assign w_div_ext = {1'b0, r_div};
    assign w_ge      = (w_sh >= w_div_ext);
    assign w_rem_nx  = w_ge ? BPM_WIDTH'(w_sh - w_div_ext) : w_sh[BPM_WIDTH-1:0];
    assign w_q_nx    = {r_dvd[PER_WIDTH-2:0], w_ge};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_rem   <= '0;
            r_dvd   <= '0;
            r_cnt   <= '0;
            r_per   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.bpm_valid) begin
                        r_div   <= bus.bpm_i;
                        r_rem   <= '0;
                        r_dvd   <= PER_WIDTH'(PER_CONST);
                        r_cnt   <= CNT_W'(PER_WIDTH - 1);
                        r_state <= S_DIV;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nx;
                    r_dvd <= w_q_nx;
                    if (r_cnt == '0) begin
                        r_per   <= w_q_nx;
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.btn_per_o     = r_per;
    assign bus.btn_per_valid = r_valid;
    assign bus.busy_o        = (r_state != S_IDLE);

`ifdef BPM2PER_PULSE_EN
    logic [PER_WIDTH-1:0] r_tick_cnt;
    logic [PER_WIDTH-1:0] r_act_per;
    logic                 r_beat;
    logic                 w_no_beat;

    // An all-ones period (bpm 0) is treated like an unloaded one so a later tempo can take over.
    assign w_no_beat = (r_act_per == '0) || (&r_act_per);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_tick_cnt <= '0;
            r_act_per  <= '0;
            r_beat     <= 1'b0;
        end else begin
            r_beat <= 1'b0;
            if (w_no_beat) begin
                r_tick_cnt <= '0;
                r_act_per  <= r_per;
            end else if (tick_i) begin
                if (r_tick_cnt == r_act_per - 1'b1) begin
                    r_tick_cnt <= '0;
                    r_beat     <= 1'b1;
                    r_act_per  <= r_per;
                end else begin
                    r_tick_cnt <= r_tick_cnt + 1'b1;
                end
            end
        end
    end

    assign beat_o = r_beat;
`endif
endmodule

// File: tb/tb_bpm2per.sv
// tb/tb_bpm2per.sv - randomized scoreboard bench for bpm2per (beat checks when BPM2PER_PULSE_EN is defined).
module tb_bpm2per;
    localparam int PW = 24;
    localparam int BW = 8;
    localparam int PC = 60000;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    bpm2per_if #(.PER_WIDTH(PW), .BPM_WIDTH(BW)) bus ();
`ifdef BPM2PER_PULSE_EN
    logic tick_i = 1'b0;
    logic beat_o;
    bit   tick_en = 1'b0;
`endif

    bpm2per #(.PER_WIDTH(PW), .BPM_WIDTH(BW), .PER_CONST(PC)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
`ifdef BPM2PER_PULSE_EN
        ,
        .tick_i(tick_i),
        .beat_o(beat_o)
`endif
    );

    typedef struct {
        logic [PW-1:0] v;
        int            c;
        int            bpm;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [PW-1:0] ref_per(input int b);
        if (b == 0) return {PW{1'b1}};
        return PW'(PC / b);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_i && bus.btn_per_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid actual=%0h required=none", bus.btn_per_o);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("period_bpm%0d", e.bpm), bus.btn_per_o, e.v);
                    check($sformatf("latency_bpm%0d", e.bpm), cyc, e.c);
                    @(negedge clk_i);
                    check("busy_after_valid", bus.busy_o, 0);
                    check("valid_one_cycle", bus.btn_per_valid, 0);
                end
            end
        end
    end

`ifdef BPM2PER_PULSE_EN
    initial forever begin
        @(negedge clk_i);
        tick_i = tick_en && (cyc % 4 == 0);
    end

    task automatic wait_beat(output int t);
        int n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!beat_o && n < 4000);
        if (!beat_o) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout actual=none required=beat");
        end
        t = cyc;
    endtask
`endif

    // Issue one accepted request; optionally pulse a competing request at busy cycle 'intrude'.
    task automatic send(input int b, input int intrude);
        int   n  = 0;
        bit   ok = 1'b1;
        exp_t e;
        @(negedge clk_i);
        while (bus.busy_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (bus.busy_o) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
        bus.bpm_i     = BW'(b);
        bus.bpm_valid = 1'b1;
        @(posedge clk_i);
        #1;
        bus.bpm_valid = 1'b0;
        e.v   = ref_per(b);
        e.c   = cyc + 24;
        e.bpm = b;
        exp_q.push_back(e);
        for (int k = 0; k < 25; k++) begin
            @(negedge clk_i);
            ok &= bus.busy_o;
            bus.bpm_valid = (k == intrude);
            bus.bpm_i     = (k == intrude) ? BW'(60) : BW'($urandom);
        end
        check($sformatf("busy_during_bpm%0d", b), ok, 1);
        @(posedge clk_i);
        #1;
        bus.bpm_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        repeat (3) @(negedge clk_i);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        int dir[5] = '{120, 1, 255, 7, 0};
        bus.bpm_i     = '0;
        bus.bpm_valid = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_per", bus.btn_per_o, 0);
        check("rst_valid", bus.btn_per_valid, 0);
        check("rst_busy", bus.busy_o, 0);
        rst_i = 1'b1;

        foreach (dir[i]) send(dir[i], -1);
        send(120, 5);
        send(120, 24);
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
            send($urandom_range(0, 255), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 24) : -1);
        end
        drain();

        @(negedge clk_i);
        bus.bpm_i     = BW'(120);
        bus.bpm_valid = 1'b1;
        @(posedge clk_i);
        #1;
        bus.bpm_valid = 1'b0;
        repeat (10) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("abort_per", bus.btn_per_o, 0);
        check("abort_valid", bus.btn_per_valid, 0);
        check("abort_busy", bus.busy_o, 0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (40) @(negedge clk_i);
        check("abort_busy_after", bus.busy_o, 0);

`ifdef BPM2PER_PULSE_EN
        begin
            int t0, t1, t2, t3;
            tick_en = 1'b1;
            send(120, -1);
            wait_beat(t0);
            wait_beat(t1);
            check("beat_interval_120", t1 - t0, 2000);
            send(240, -1);
            wait_beat(t2);
            wait_beat(t3);
            check("beat_interval_switch", t2 - t1, 2000);
            check("beat_interval_240", t3 - t2, 1000);
            tick_en = 1'b0;
        end
`endif
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
